// File: rtl/dds_profile_sequencer.sv
// Steps a programmable profile table into the DDS wave controller's frequency, phase and waveform inputs.
// Optional macro DDS_PROFILE_RAMP_EN: adds ramp_step and slews fre_x toward each profile's frequency.
module dds_profile_sequencer #(
  parameter int  FRE_WIDTH   = 10,
  parameter int  PHA_WIDTH   = 8,
  parameter int  DEPTH_LOG2  = 3,
  parameter int  DWELL_WIDTH = 16,
  localparam int PROF_W      = 4 + FRE_WIDTH + 2*PHA_WIDTH + DWELL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [DEPTH_LOG2-1:0] cfg_addr,
  input  logic [PROF_W-1:0]     cfg_wdata,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [DEPTH_LOG2-1:0] last_idx,
`ifdef DDS_PROFILE_RAMP_EN
  input  logic [FRE_WIDTH-1:0]  ramp_step,
`endif
  output logic [FRE_WIDTH-1:0]  fre_x,
  output logic [PHA_WIDTH-1:0]  pha_x,
  output logic [PHA_WIDTH-1:0]  pha_y,
  output logic [3:0]            wave_sel,
  output logic                  upd,
  output logic [DEPTH_LOG2-1:0] prof_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int                     DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);
  localparam logic [DEPTH_LOG2-1:0]  IDX_ONE   = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [3:0]             wave_sel;
    logic [FRE_WIDTH-1:0]   fre;
    logic [PHA_WIDTH-1:0]   pha_x;
    logic [PHA_WIDTH-1:0]   pha_y;
    logic [DWELL_WIDTH-1:0] dwell;
  } prof_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                 state_q, state_d;
  prof_t                  table_q [DEPTH];
  prof_t                  cur;
  logic [DEPTH_LOG2-1:0]  idx_q, last_q;
  logic                   loop_q;
  logic [DWELL_WIDTH-1:0] cnt_q;
  logic                   accept, load_fire, dwell_end, more, seq_fin;

  assign cur = table_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = LOAD;
      LOAD: state_d = stop ? IDLE : RUN;
      RUN: begin
        if (stop)                    state_d = IDLE;
        else if (cnt_q == DWELL_ONE) state_d = ((idx_q < last_q) || loop_q) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    accept    = (state_q == IDLE) && start && !stop;
    load_fire = (state_q == LOAD) && !stop;
    dwell_end = (state_q == RUN) && !stop && (cnt_q == DWELL_ONE);
    more      = (idx_q < last_q) || loop_q;
    seq_fin   = dwell_end && !more;
  end

  // A LOAD reads the array before a same-edge write lands, so it sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (cfg_we) begin
      table_q[cfg_addr] <= prof_t'(cfg_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
    end else if (accept) begin
      idx_q  <= '0;
      last_q <= last_idx;
      loop_q <= loop_en;
    end else if (dwell_end && more) begin
      idx_q  <= (idx_q < last_q) ? idx_q + IDX_ONE : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pha_x    <= '0;
      pha_y    <= '0;
      wave_sel <= 4'b0001;
      prof_idx <= '0;
      cnt_q    <= '0;
      upd      <= 1'b0;
      done     <= 1'b0;
    end else begin
      upd  <= load_fire;
      done <= seq_fin;
      if (load_fire) begin
        pha_x    <= cur.pha_x;
        pha_y    <= cur.pha_y;
        wave_sel <= cur.wave_sel;
        prof_idx <= idx_q;
        cnt_q    <= (cur.dwell == '0) ? DWELL_ONE : cur.dwell;
      end else if (state_q == RUN && cnt_q != '0) begin
        cnt_q    <= cnt_q - DWELL_ONE;
      end
    end
  end

`ifdef DDS_PROFILE_RAMP_EN
  logic [FRE_WIDTH-1:0] tgt_q, fre_next;

  // Saturating step toward the target; the distance test keeps the arithmetic free of wrap.
  always_comb begin
    fre_next = tgt_q;
    if (ramp_step != '0) begin
      if (fre_x < tgt_q) begin
        if ((tgt_q - fre_x) > ramp_step) fre_next = fre_x + ramp_step;
      end else if ((fre_x - tgt_q) > ramp_step) begin
        fre_next = fre_x - ramp_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fre_x <= '0;
      tgt_q <= '0;
    end else if (load_fire) begin
      tgt_q <= cur.fre;
      if (ramp_step == '0) fre_x <= cur.fre;
    end else if (state_q == RUN && !stop) begin
      fre_x <= fre_next;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)            fre_x <= '0;
    else if (load_fire) fre_x <= cur.fre;
  end
`endif

endmodule
